// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the rv32i data path.
// Detects fetch/illegal/data faults and maskable interrupts, records trap
// state, executes mret, drives the PC redirect and keeps a 64-bit cycle counter.
module csr_trap_unit #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned ROM_BYTES   = 64,
  parameter int unsigned RAM_BYTES   = 64,
  parameter int unsigned NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0004
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic              csr_w,
  input  logic [11:0]       csr,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              trap,
  output logic [31:0]       trap_addr
);

  localparam logic [ADDR_W:0] ROM_LIM  = (ADDR_W+1)'(ROM_BYTES);
  localparam logic [ADDR_W:0] RAM_LIM  = (ADDR_W+1)'(RAM_BYTES);
  localparam logic [31:0]     MRET_OP  = 32'h3020_0073;
  localparam logic [6:0]      OP_SYS   = 7'b1110011;

  // Architectural state
  logic               mst_mie_q,  mst_mie_d;
  logic               mst_mpie_q, mst_mpie_d;
  logic [NUM_IRQ-1:0] mie_q,      mie_d;
  logic [31:0]        mtvec_q,    mtvec_d;
  logic [31:0]        mepc_q,     mepc_d;
  logic [31:0]        mcause_q,   mcause_d;
  logic [31:0]        mtval_q,    mtval_d;
  logic [63:0]        mcycle_q,   mcycle_d;

  // Trap detection signals
  logic        op_legal;
  logic        fetch_fault;
  logic        data_fault;
  logic        exc;
  logic        irq_take;
  logic [4:0]  irq_code;
  logic        is_mret;
  logic        trap_raw;
  logic        trap_entry;
  logic [31:0] cause;
  logic [31:0] tval;
  logic [31:0] base;
  logic [31:0] target;
  logic [31:0] pc32;
  logic        csr_we;

  assign pc32 = 32'(pc);
  assign base = {mtvec_q[31:2], 2'b00};

  // Opcode legality decode
  always_comb begin
    op_legal = 1'b0;
    case (instr[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
      7'b0010111, 7'b1110011, 7'b0001111: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

  // Lowest-index enabled interrupt, gated by mstatus.MIE
  always_comb begin
    irq_take = 1'b0;
    irq_code = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!irq_take && irq[i] && mie_q[i]) begin
        irq_take = 1'b1;
        irq_code = 5'(16 + i);
      end
    end
    irq_take = irq_take & mst_mie_q;
  end

  // Cause priority and redirect target; mret yields to any active cause
  always_comb begin
    fetch_fault = ({1'b0, pc} >= ROM_LIM);
    data_fault  = (mem_r | mem_w) && ({1'b0, ram_addr} >= RAM_LIM);
    exc         = fetch_fault | ~op_legal | data_fault;
    is_mret     = (instr == MRET_OP) && !exc && !irq_take;
    trap_entry  = exc | irq_take;
    trap_raw    = trap_entry | is_mret;
    cause       = '0;
    tval        = '0;
    target      = '0;
    if (fetch_fault) begin
      cause  = 32'd1;
      tval   = pc32;
      target = base;
    end else if (!op_legal) begin
      cause  = 32'd2;
      tval   = instr;
      target = base;
    end else if (data_fault) begin
      cause  = mem_r ? 32'd5 : 32'd7;
      tval   = 32'(ram_addr);
      target = base;
    end else if (irq_take) begin
      cause  = {1'b1, 26'd0, irq_code};
      target = mtvec_q[0] ? base + {25'd0, irq_code, 2'b00} : base;
    end else if (is_mret) begin
      target = mepc_q;
    end
  end

  // Outputs are forced quiet while reset is held
  assign trap      = rst_n & trap_raw;
  assign trap_addr = (rst_n && trap_raw) ? target : '0;

  assign csr_we = csr_w && (instr[6:0] == OP_SYS) && !trap_raw;

  // Next-state: CSR writes first, trap entry / mret override afterwards
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    if (csr_we) begin
      case (csr)
        12'h300: begin
          mst_mie_d  = wd[3];
          mst_mpie_d = wd[7];
        end
        12'h304: mie_d    = wd[NUM_IRQ-1:0];
        12'h305: mtvec_d  = {wd[31:2], 1'b0, wd[0]};
        12'h341: mepc_d   = {wd[31:2], 2'b00};
        12'h342: mcause_d = wd;
        12'h343: mtval_d  = wd;
        // A write to either half freezes the whole counter for this cycle
        12'hB00: mcycle_d = {mcycle_q[63:32], wd};
        12'hB80: mcycle_d = {wd, mcycle_q[31:0]};
        default: ;
      endcase
    end
    if (trap_entry) begin
      mepc_d     = {pc32[31:2], 2'b00};
      mcause_d   = cause;
      mtval_d    = tval;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (is_mret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
    end
  end

  // CSR read mux
  always_comb begin
    rd = '0;
    case (csr)
      12'h300: rd = {24'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
      12'h304: rd = {{(32-NUM_IRQ){1'b0}}, mie_q};
      12'h305: rd = mtvec_q;
      12'h341: rd = mepc_q;
      12'h342: rd = mcause_q;
      12'h343: rd = mtval_q;
      12'h344: rd = {{(32-NUM_IRQ){1'b0}}, irq};
      12'hB00: rd = mcycle_q[31:0];
      12'hB80: rd = mcycle_q[63:32];
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: a behavioural model is compared
// against the DUT every falling edge, plus directed literal expectations.
module tb_csr_trap_unit;

  localparam int NIRQ = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = 32'h0000_0013;
  logic [15:0] pc = '0;
  logic [15:0] ram_addr = '0;
  logic        mem_r = 1'b0;
  logic        mem_w = 1'b0;
  logic [3:0]  irq = '0;
  logic        csr_w = 1'b0;
  logic [11:0] csr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        trap;
  logic [31:0] trap_addr;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  csr_trap_unit #(
    .ADDR_W(16), .ROM_BYTES(64), .RAM_BYTES(64), .NUM_IRQ(NIRQ),
    .MTVEC_RESET(32'h0000_0004)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc(pc), .ram_addr(ram_addr),
    .mem_r(mem_r), .mem_w(mem_w), .irq(irq), .csr_w(csr_w), .csr(csr),
    .wd(wd), .rd(rd), .trap(trap), .trap_addr(trap_addr)
  );

  always #5 clk = ~clk;

  // Model state: plain register images
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle;
  logic [6:0]  legal_ops [0:10] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                    7'b0100011, 7'b1100011, 7'b1101111,
                                    7'b1100111, 7'b0110111, 7'b0010111,
                                    7'b1110011, 7'b0001111};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mstatus = 0; m_mie = 0; m_mtvec = 32'h4; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_cycle = 0;
  endtask

  // kind: 0 none, 1 exception, 2 interrupt, 3 mret
  task automatic model_eval(output logic e_trap, output logic [31:0] e_addr,
                            output int kind, output logic [31:0] e_cause,
                            output logic [31:0] e_tval);
    bit legal = 0;
    logic [31:0] base = m_mtvec & ~32'd3;
    foreach (legal_ops[k]) if (legal_ops[k] == instr[6:0]) legal = 1;
    kind = 0; e_cause = 0; e_tval = 0; e_addr = 0;
    if (32'(pc) >= 64) begin
      kind = 1; e_cause = 1; e_tval = 32'(pc);
    end else if (!legal) begin
      kind = 1; e_cause = 2; e_tval = instr;
    end else if ((mem_r || mem_w) && 32'(ram_addr) >= 64) begin
      kind = 1; e_cause = mem_r ? 5 : 7; e_tval = 32'(ram_addr);
    end else if (m_mstatus[3]) begin
      for (int i = NIRQ - 1; i >= 0; i--)
        if (irq[i] && m_mie[i]) begin
          kind = 2; e_cause = 32'h8000_0000 | 32'(16 + i);
        end
    end
    if (kind == 0 && instr == 32'h3020_0073) kind = 3;
    if (kind == 1) e_addr = base;
    else if (kind == 2) e_addr = m_mtvec[0] ? base + 4 * (e_cause & 31) : base;
    else if (kind == 3) e_addr = m_mepc;
    e_trap = (kind != 0);
    if (!rst_n) begin e_trap = 0; e_addr = 0; end
  endtask

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return 32'(irq);
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      default: return 0;
    endcase
  endfunction

  // Model advances on each rising edge, resets asynchronously
  always @(posedge clk or negedge rst_n) begin
    logic t; logic [31:0] a, c, v; int kind; bit cyc_wr;
    if (!rst_n) model_reset();
    else begin
      model_eval(t, a, kind, c, v);
      cyc_wr = 0;
      if (!t && csr_w && instr[6:0] == 7'b1110011) begin
        case (csr)
          12'h300: m_mstatus = wd & 32'h88;
          12'h304: m_mie = wd & 32'hF;
          12'h305: m_mtvec = wd & ~32'd2;
          12'h341: m_mepc = wd & ~32'd3;
          12'h342: m_mcause = wd;
          12'h343: m_mtval = wd;
          12'hB00: begin m_cycle[31:0] = wd; cyc_wr = 1; end
          12'hB80: begin m_cycle[63:32] = wd; cyc_wr = 1; end
          default: ;
        endcase
      end
      if (!cyc_wr) m_cycle = m_cycle + 1;
      if (kind == 1 || kind == 2) begin
        m_mepc = 32'(pc) & ~32'd3; m_mcause = c; m_mtval = v;
        m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      end else if (kind == 3) begin
        m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end
    end
  end

  // Continuous comparison against the model
  always @(negedge clk) begin
    logic t; logic [31:0] a, c, v; int kind;
    if (run) begin
      model_eval(t, a, kind, c, v);
      chk("trap", 64'(trap), 64'(t));
      chk("trap_addr", 64'(trap_addr), 64'(a));
      chk($sformatf("rd_%h", csr), 64'(rd), 64'(model_rd(csr)));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    instr = 32'h0000_0013; pc = 16'd0; ram_addr = 16'd0; mem_r = 0; mem_w = 0;
    irq = '0; csr_w = 0; wd = '0;
  endtask

  // Read a CSR combinationally within the current cycle
  task automatic rdchk(input logic [11:0] a, input logic [31:0] exp, input string name);
    csr = a; #1;
    chk(name, 64'(rd), 64'(exp));
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    step(); idle();
    instr = {a, 20'h01073}; csr = a; wd = d; csr_w = 1;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 run = 1'b1;
    // Reset state, trap suppressed even with a faulting instruction
    instr = 32'h0000_007F;
    rdchk(12'h305, 32'h4, "reset_mtvec");
    chk("reset_trap", 64'(trap), 64'd0);
    chk("reset_trap_addr", 64'(trap_addr), 64'd0);
    step(); step();
    rst_n = 1'b1; idle();
    rdchk(12'h300, 32'h0, "reset_mstatus");

    // Illegal opcode with a would-be CSR write
    step(); idle();
    instr = 32'h0050_207F; pc = 16'd24; csr = 12'h342; csr_w = 1; wd = 32'd100; #1;
    chk("illegal_trap", 64'(trap), 64'd1);
    chk("illegal_addr", 64'(trap_addr), 64'd4);
    step(); idle();
    rdchk(12'h342, 32'd2, "illegal_mcause");
    rdchk(12'h341, 32'd24, "illegal_mepc");
    rdchk(12'h343, 32'h0050_207F, "illegal_mtval");

    // Legal CSR write to mtvec, bit1 forced low
    step(); idle();
    instr = 32'h3050_2073; pc = 16'd28; csr = 12'h305; wd = 32'h103; csr_w = 1; #1;
    chk("csrw_trap", 64'(trap), 64'd0);
    step(); idle();
    rdchk(12'h305, 32'h101, "csrw_mtvec");

    // Store fault, then same stimulus with faulting pc
    step(); idle();
    instr = 32'h00A0_2023; pc = 16'd32; ram_addr = 16'd76; mem_w = 1; #1;
    chk("store_addr", 64'(trap_addr), 64'h100);
    step(); idle();
    rdchk(12'h342, 32'd7, "store_mcause");
    rdchk(12'h343, 32'd76, "store_mtval");
    step(); idle();
    instr = 32'h00A0_2023; pc = 16'd112; ram_addr = 16'd76; mem_w = 1;
    step(); idle();
    rdchk(12'h342, 32'd1, "fetch_mcause");
    rdchk(12'h343, 32'd112, "fetch_mtval");

    // Vectored interrupt
    csr_write(12'h304, 32'h6);
    csr_write(12'h300, 32'h8);
    step(); idle();
    irq = 4'b0110; pc = 16'd44; #1;
    chk("irq_trap", 64'(trap), 64'd1);
    chk("irq_addr", 64'(trap_addr), 64'h144);
    step(); idle();
    irq = 4'b0110; #1;
    chk("irq_held_no_trap", 64'(trap), 64'd0);
    rdchk(12'h342, 32'h8000_0011, "irq_mcause");
    rdchk(12'h300, 32'h80, "irq_mstatus");

    // mret, then exception racing an interrupt
    csr_write(12'h341, 32'd40);
    step(); idle();
    instr = 32'h3020_0073; #1;
    chk("mret_trap", 64'(trap), 64'd1);
    chk("mret_addr", 64'(trap_addr), 64'd40);
    step(); idle();
    rdchk(12'h300, 32'h88, "mret_mstatus");
    irq = 4'b0010; instr = 32'h0000_007F; pc = 16'd48; #1;
    chk("exc_vs_irq_addr", 64'(trap_addr), 64'h100);
    step(); idle();
    rdchk(12'h342, 32'd2, "exc_vs_irq_mcause");
    rdchk(12'h343, 32'h7F, "exc_vs_irq_mtval");

    // Counter write and carry into the high half
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_write(12'hB80, 32'h0);
    step(); idle();
    rdchk(12'hB00, 32'hFFFF_FFFF, "cyc_lo_written");
    rdchk(12'hB80, 32'h0, "cyc_hi_written");
    step(); idle();
    rdchk(12'hB80, 32'h1, "cyc_hi_carry");
    rdchk(12'hB00, 32'h0, "cyc_lo_wrap");

    // Asynchronous reset mid-trap
    step(); idle();
    instr = 32'h0000_007F; pc = 16'd52;
    rst_n = 1'b0;
    rdchk(12'h305, 32'h4, "async_mtvec");
    rdchk(12'h342, 32'h0, "async_mcause");
    rdchk(12'hB80, 32'h0, "async_cycle_hi");
    chk("async_trap", 64'(trap), 64'd0);
    step();
    rst_n = 1'b1; idle();
    rdchk(12'h341, 32'h0, "post_reset_mepc");
    step(); step();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
